// File: rtl/vic20_keymatrix.sv
// Keyboard-matrix engine: queues host key events, translates them through an external
// row/column table and drives a reference-counted matrix seen by the VIA as row-sense lines.
module vic20_keymatrix #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned SETTLE     = 4096,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_key_valid,
    input  logic [6:0]      i_key_code,
    input  logic            i_key_press,
    output logic            o_key_ready,
    input  logic            i_all_up,
    output logic [6:0]      o_tbl_code,
    input  logic [3:0]      i_tbl_row,
    input  logic [3:0]      i_tbl_row_s,
    input  logic [2:0]      i_tbl_col,
    input  logic [2:0]      i_tbl_col_s,
    input  logic [COLS-1:0] i_col_sel_n,
    output logic [ROWS-1:0] o_row_sense_n,
    output logic            o_busy,
    output logic            o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLook,
        StShOn,
        StWaitOn,
        StKeyOn,
        StKeyOff,
        StWaitOff,
        StShOff
    } state_e;

    state_e r_state;

    // Event queue: {code, press}
    logic [7:0]  r_fifo_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    // Per-code record {row, col, row_s, col_s}; held bits live in flops so all_up clears them at once
    logic [13:0]  r_rec_mem [128];
    logic [13:0]  r_rec;
    logic [127:0] r_held;

    logic [6:0]    r_code;
    logic          r_press;
    logic [3:0]    r_row;
    logic [2:0]    r_col;
    logic [3:0]    r_row_s;
    logic [2:0]    r_col_s;
    logic [SW-1:0] r_settle;
    logic          r_overflow;

    logic [CNT_W-1:0] r_cnt [ROWS][COLS];
    logic [COLS-1:0]  w_pressed [ROWS];
    logic [ROWS-1:0]  w_sense_n;
    logic [ROWS-1:0]  r_row_sense_n;

    logic       w_mapped;
    logic       w_shifted;
    logic       w_rec_we;
    logic       w_cnt_inc;
    logic       w_cnt_dec;
    logic [3:0] w_tgt_row;
    logic [2:0] w_tgt_col;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_fifo_mem[r_rd_ptr[AW-1:0]];
    assign w_pop   = (r_state == StIdle) && !w_empty && !i_all_up;
    // A pop in the same cycle frees a slot, so a full queue still accepts
    assign o_key_ready = !w_full || w_pop;
    assign w_push  = i_key_valid && o_key_ready && !i_all_up;

    assign w_mapped  = (32'(i_tbl_row) < ROWS);
    assign w_shifted = (32'(i_tbl_row_s) < ROWS);
    assign w_rec_we  = (r_state == StLook) && r_press && !r_held[r_code] && w_mapped &&
                       !i_all_up;

    assign o_tbl_code    = r_code;
    assign o_row_sense_n = r_row_sense_n;
    assign o_busy        = (r_state != StIdle) || !w_empty;
    assign o_overflow    = r_overflow;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_all_up) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= {i_key_code, i_key_press};
        if (w_rec_we) r_rec_mem[r_code] <= {i_tbl_row, i_tbl_col, i_tbl_row_s, i_tbl_col_s};
        if (w_pop) r_rec <= r_rec_mem[w_head[7:1]];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow <= 1'b0;
        end else if (i_key_valid && !o_key_ready) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= StIdle;
            r_code   <= '0;
            r_press  <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_row_s  <= '0;
            r_col_s  <= '0;
            r_settle <= '0;
            r_held   <= '0;
        end else if (i_all_up) begin
            r_state <= StIdle;
            r_held  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_code  <= w_head[7:1];
                        r_press <= w_head[0];
                        r_state <= StLook;
                    end
                end
                StLook: begin
                    if (r_press) begin
                        if (r_held[r_code] || !w_mapped) begin
                            r_state <= StIdle;
                        end else begin
                            r_held[r_code] <= 1'b1;
                            r_row   <= i_tbl_row;
                            r_col   <= i_tbl_col;
                            r_row_s <= i_tbl_row_s;
                            r_col_s <= i_tbl_col_s;
                            r_state <= w_shifted ? StShOn : StKeyOn;
                        end
                    end else if (r_held[r_code]) begin
                        // Breaks replay the stored record, never the live table
                        r_held[r_code] <= 1'b0;
                        {r_row, r_col, r_row_s, r_col_s} <= r_rec;
                        r_state <= StKeyOff;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StShOn: begin
                    r_settle <= SETTLE_LOAD;
                    r_state  <= StWaitOn;
                end
                StWaitOn: begin
                    if (r_settle == '0) r_state <= StKeyOn;
                    else                r_settle <= r_settle - SW'(1);
                end
                StKeyOn: begin
                    r_state <= StIdle;
                end
                StKeyOff: begin
                    if (32'(r_row_s) < ROWS) begin
                        r_settle <= SETTLE_LOAD;
                        r_state  <= StWaitOff;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWaitOff: begin
                    if (r_settle == '0) r_state <= StShOff;
                    else                r_settle <= r_settle - SW'(1);
                end
                StShOff: begin
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_cnt_inc = (r_state == StShOn) || (r_state == StKeyOn);
        w_cnt_dec = (r_state == StKeyOff) || (r_state == StShOff);
        if ((r_state == StShOn) || (r_state == StShOff)) begin
            w_tgt_row = r_row_s;
            w_tgt_col = r_col_s;
        end else begin
            w_tgt_row = r_row;
            w_tgt_col = r_col;
        end
    end

    // Saturating up, floor-at-zero down; shared positions stay pressed until the last release
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    r_cnt[r][c] <= '0;
                end
            end
        end else begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (i_all_up) begin
                        r_cnt[r][c] <= '0;
                    end else if ((32'(w_tgt_row) == r) && (32'(w_tgt_col) == c)) begin
                        if (w_cnt_inc && (r_cnt[r][c] != {CNT_W{1'b1}})) begin
                            r_cnt[r][c] <= r_cnt[r][c] + 1'b1;
                        end else if (w_cnt_dec && (r_cnt[r][c] != '0)) begin
                            r_cnt[r][c] <= r_cnt[r][c] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                w_pressed[r][c] = (r_cnt[r][c] != '0);
            end
            w_sense_n[r] = ~|(w_pressed[r] & ~i_col_sel_n);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_row_sense_n <= '1;
        end else begin
            r_row_sense_n <= w_sense_n;
        end
    end

endmodule

// File: tb/tb_vic20_keymatrix.sv
// Self-checking bench for vic20_keymatrix: directed timing scenarios plus random event
// sequences compared against a per-code / per-position reference model.
module tb_vic20_keymatrix;

    localparam int MROWS = 8;
    localparam int MCOLS = 8;
    localparam int CMAX  = 3;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [6:0] key_code;
    logic       key_press;
    logic       key_ready;
    logic       all_up;
    logic [6:0] tbl_code;
    logic [3:0] tbl_row;
    logic [3:0] tbl_row_s;
    logic [2:0] tbl_col;
    logic [2:0] tbl_col_s;
    logic [7:0] col_sel_n;
    logic [7:0] row_sense_n;
    logic       busy;
    logic       overflow;

    int checks;
    int errors;

    logic [3:0] t_row   [128];
    logic [2:0] t_col   [128];
    logic [3:0] t_row_s [128];
    logic [2:0] t_col_s [128];

    int         m_cnt   [MROWS][MCOLS];
    bit         m_held  [128];
    int         m_rr    [128];
    int         m_rc    [128];
    int         m_rrs   [128];
    int         m_rcs   [128];

    logic [6:0] pool [12];

    assign tbl_row   = t_row[tbl_code];
    assign tbl_col   = t_col[tbl_code];
    assign tbl_row_s = t_row_s[tbl_code];
    assign tbl_col_s = t_col_s[tbl_code];

    vic20_keymatrix #(
        .ROWS       (8),
        .COLS       (8),
        .CNT_W      (2),
        .SETTLE     (16),
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_key_valid   (key_valid),
        .i_key_code    (key_code),
        .i_key_press   (key_press),
        .o_key_ready   (key_ready),
        .i_all_up      (all_up),
        .o_tbl_code    (tbl_code),
        .i_tbl_row     (tbl_row),
        .i_tbl_row_s   (tbl_row_s),
        .i_tbl_col     (tbl_col),
        .i_tbl_col_s   (tbl_col_s),
        .i_col_sel_n   (col_sel_n),
        .o_row_sense_n (row_sense_n),
        .o_busy        (busy),
        .o_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < MROWS; r++)
            for (int c = 0; c < MCOLS; c++) m_cnt[r][c] = 0;
        for (int i = 0; i < 128; i++) m_held[i] = 1'b0;
    endtask

    // Key events in arrival order: make presses shift then key, break releases the stored pair
    task automatic model_event(input logic [6:0] code, input bit press);
        if (press) begin
            if (!m_held[code] && (int'(t_row[code]) < MROWS)) begin
                m_held[code] = 1'b1;
                m_rr[code]  = int'(t_row[code]);
                m_rc[code]  = int'(t_col[code]);
                m_rrs[code] = int'(t_row_s[code]);
                m_rcs[code] = int'(t_col_s[code]);
                if (m_rrs[code] < MROWS && m_cnt[m_rrs[code]][m_rcs[code]] < CMAX)
                    m_cnt[m_rrs[code]][m_rcs[code]]++;
                if (m_cnt[m_rr[code]][m_rc[code]] < CMAX) m_cnt[m_rr[code]][m_rc[code]]++;
            end
        end else if (m_held[code]) begin
            m_held[code] = 1'b0;
            if (m_cnt[m_rr[code]][m_rc[code]] > 0) m_cnt[m_rr[code]][m_rc[code]]--;
            if (m_rrs[code] < MROWS && m_cnt[m_rrs[code]][m_rcs[code]] > 0)
                m_cnt[m_rrs[code]][m_rcs[code]]--;
        end
    endtask

    function automatic logic [7:0] model_sense(input logic [7:0] csn);
        logic [7:0] s;
        s = 8'hFF;
        for (int r = 0; r < MROWS; r++)
            for (int c = 0; c < MCOLS; c++)
                if (m_cnt[r][c] != 0 && !csn[c]) s[r] = 1'b0;
        return s;
    endfunction

    task automatic push(input logic [6:0] code, input bit press);
        int t;
        t = 0;
        while (!key_ready && t < 400) begin
            step(1);
            t++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("FAIL push_ready_timeout: key_ready=%0b required 1 (code %h)", key_ready, code);
        end
        key_valid = 1'b1;
        key_code  = code;
        key_press = press;
        step(1);
        key_valid = 1'b0;
        model_event(code, press);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            step(1);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
        step(1);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        key_press = 1'b0;
        all_up    = 1'b0;
        col_sel_n = 8'h00;
        step(2);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL reset_row_sense: got %h required ff", row_sense_n);
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_key_ready: got %b required 1", key_ready);
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_ovf: got busy=%b ovf=%b required 0 0", busy, overflow);
        end
        checks++;
        if (tbl_code !== 7'h00) begin
            errors++;
            $display("FAIL reset_tbl_code: got %h required 00", tbl_code);
        end
        #2 reset_n = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || key_ready !== 1'b1 || row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b ready=%b rs=%h required 0 1 ff",
                     busy, key_ready, row_sense_n);
        end
    endtask

    task automatic test_plain();
        col_sel_n = 8'hFD;
        step(1);
        push(7'h04, 1'b1);
        step(3);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL plain_make_early: got %h required ff at accept+3", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFB) begin
            errors++;
            $display("FAIL plain_make: got %h required fb at accept+4", row_sense_n);
        end
        wait_idle();
        col_sel_n = 8'hFF;
        #1;
        checks++;
        if (row_sense_n !== 8'hFB) begin
            errors++;
            $display("FAIL colsel_latency_hold: got %h required fb", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL colsel_latency: got %h required ff", row_sense_n);
        end
        col_sel_n = 8'hFD;
        step(1);
        push(7'h04, 1'b0);
        step(3);
        checks++;
        if (row_sense_n !== 8'hFB) begin
            errors++;
            $display("FAIL plain_break_early: got %h required fb", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL plain_break: got %h required ff", row_sense_n);
        end
        wait_idle();
    endtask

    task automatic test_shifted();
        col_sel_n = 8'hFD;
        step(1);
        push(7'h52, 1'b1);
        step(3);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL shift_make_early: got %h required ff", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hF7) begin
            errors++;
            $display("FAIL shift_make_shift: got %h required f7", row_sense_n);
        end
        col_sel_n = 8'h7F;
        step(16);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL shift_make_key_early: got %h required ff", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hF7) begin
            errors++;
            $display("FAIL shift_make_key: got %h required f7", row_sense_n);
        end
        wait_idle();
        push(7'h52, 1'b0);
        step(3);
        checks++;
        if (row_sense_n !== 8'hF7) begin
            errors++;
            $display("FAIL shift_break_key_early: got %h required f7", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL shift_break_key: got %h required ff", row_sense_n);
        end
        col_sel_n = 8'hFD;
        step(16);
        checks++;
        if (row_sense_n !== 8'hF7) begin
            errors++;
            $display("FAIL shift_break_shift_early: got %h required f7", row_sense_n);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL shift_break_shift: got %h required ff", row_sense_n);
        end
        wait_idle();
    endtask

    task automatic test_shared();
        col_sel_n = 8'h7F;
        push(7'h2A, 1'b1);
        push(7'h4C, 1'b1);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFE) begin
            errors++;
            $display("FAIL shared_both: got %h required fe", row_sense_n);
        end
        push(7'h2A, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFE) begin
            errors++;
            $display("FAIL shared_one_left: got %h required fe", row_sense_n);
        end
        push(7'h4C, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL shared_none: got %h required ff", row_sense_n);
        end
    endtask

    task automatic test_repeat();
        col_sel_n = 8'hFD;
        for (int i = 0; i < 3; i++) push(7'h04, 1'b1);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFB) begin
            errors++;
            $display("FAIL repeat_held: got %h required fb", row_sense_n);
        end
        push(7'h04, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL repeat_release: got %h required ff", row_sense_n);
        end
        push(7'h04, 1'b1);
        push(7'h2A, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFB) begin
            errors++;
            $display("FAIL stray_break_other: got %h required fb", row_sense_n);
        end
        col_sel_n = 8'h7F;
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL stray_break_pos: got %h required ff", row_sense_n);
        end
        col_sel_n = 8'hFD;
        push(7'h04, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL stray_cleanup: got %h required ff", row_sense_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] csn;
        logic [7:0] exp_s;
        int         n;
        for (int round = 0; round < 30; round++) begin
            n = int'($urandom_range(1, 6));
            for (int e = 0; e < n; e++) begin
                push(pool[$urandom_range(0, 11)], 1'($urandom_range(0, 1)));
            end
            wait_idle();
            for (int k = 0; k < 3; k++) begin
                if (k == 0) csn = ~(8'h01 << $urandom_range(0, 7));
                else        csn = 8'($urandom);
                col_sel_n = csn;
                step(1);
                exp_s = model_sense(csn);
                checks++;
                if (row_sense_n !== exp_s) begin
                    errors++;
                    $display("FAIL random_sense round %0d: col_sel_n=%h got %h required %h",
                             round, csn, row_sense_n, exp_s);
                end
            end
        end
    endtask

    task automatic test_overflow();
        col_sel_n = 8'h00;
        all_up = 1'b1;
        step(1);
        all_up = 1'b0;
        model_clear();
        step(1);
        push(7'h52, 1'b1);
        step(3);
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_code  = 7'h04;
            key_press = 1'b1;
            step(1);
        end
        checks++;
        if (key_ready !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL queue_full: got ready=%b ovf=%b required 0 0", key_ready, overflow);
        end
        step(1);
        key_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b required 1", overflow);
        end
        all_up = 1'b1;
        step(1);
        all_up = 1'b0;
        model_clear();
        checks++;
        if (busy !== 1'b0 || key_ready !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL all_up_state: got busy=%b ready=%b ovf=%b required 0 1 1",
                     busy, key_ready, overflow);
        end
        step(1);
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL all_up_sense: got %h required ff", row_sense_n);
        end
        step(30);
        checks++;
        if (row_sense_n !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL all_up_flushed: got rs=%h busy=%b required ff 0", row_sense_n, busy);
        end
        push(7'h52, 1'b1);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hF7) begin
            errors++;
            $display("FAIL all_up_held_clear: got %h required f7", row_sense_n);
        end
        push(7'h52, 1'b0);
        wait_idle();
        checks++;
        if (row_sense_n !== 8'hFF) begin
            errors++;
            $display("FAIL all_up_rebreak: got %h required ff", row_sense_n);
        end
    endtask

    task automatic test_reset_mid();
        col_sel_n = 8'h00;
        push(7'h52, 1'b1);
        step(6);
        checks++;
        if (row_sense_n !== 8'hF7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_on: got rs=%h busy=%b required f7 1", row_sense_n, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (row_sense_n !== 8'hFF || busy !== 1'b0 || key_ready !== 1'b1 ||
            overflow !== 1'b0 || tbl_code !== 7'h00) begin
            errors++;
            $display("FAIL mid_reset: got rs=%h busy=%b ready=%b ovf=%b code=%h required ff 0 1 0 00",
                     row_sense_n, busy, key_ready, overflow, tbl_code);
        end
        step(2);
        #2 reset_n = 1'b1;
        model_clear();
        step(40);
        checks++;
        if (row_sense_n !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got rs=%h busy=%b required ff 0", row_sense_n, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) begin
            t_row[i] = 4'($urandom_range(0, 9));
            t_col[i] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) t_row_s[i] = 4'hF;
            else                           t_row_s[i] = 4'($urandom_range(0, 9));
            t_col_s[i] = 3'($urandom_range(0, 7));
        end
        t_row[7'h04] = 4'd2; t_col[7'h04] = 3'd1; t_row_s[7'h04] = 4'hF; t_col_s[7'h04] = 3'd0;
        t_row[7'h52] = 4'd3; t_col[7'h52] = 3'd7; t_row_s[7'h52] = 4'd3; t_col_s[7'h52] = 3'd1;
        t_row[7'h2A] = 4'd0; t_col[7'h2A] = 3'd7; t_row_s[7'h2A] = 4'hF; t_col_s[7'h2A] = 3'd0;
        t_row[7'h4C] = 4'd0; t_col[7'h4C] = 3'd7; t_row_s[7'h4C] = 4'hF; t_col_s[7'h4C] = 3'd0;
        pool[0] = 7'h04;
        pool[1] = 7'h52;
        pool[2] = 7'h2A;
        pool[3] = 7'h4C;
        for (int i = 4; i < 12; i++) pool[i] = 7'(7'h10 + i);
        model_clear();

        test_reset();
        test_plain();
        test_shifted();
        test_shared();
        test_repeat();
        test_random();
        test_overflow();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vic20_keymatrix.md
# vic20_keymatrix

Sequential keyboard-matrix engine between the FPGA Companion key-event stream and the VIA keyboard ports. Host key events (USB HID codes, modifiers remapped to 0x68+) are queued, translated through an external row/column lookup table, and applied to a reference-counted matrix. Keys needing a forced shift are sequenced as shift → settle → key on press and key → settle → shift on release. The matrix is exposed as a registered active-low row-sense port for the VIA column scan. Geometry, settle time and queue depth are parametrised.

## Interface
- ROWS, 8, matrix rows; a table row value ≥ ROWS means "unmapped".
- COLS, 8, matrix columns.
- CNT_W, 2, width of the per-position press counter.
- SETTLE, 4096, clk cycles between the shift and key steps; minimum 1.
- FIFO_DEPTH, 8, event queue depth; power of two, ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_valid  in  1  event strobe; accepted when key_ready=1.
- key_code  in  7  host key code.
- key_press  in  1  1 = make, 0 = break.
- key_ready  out  1  queue not full.
- all_up  in  1  one-cycle pulse: release every key and flush the queue.
- tbl_code  out  7  code presented to the lookup table.
- tbl_row, tbl_row_s  in  4  table row, plain and forced-shift.
- tbl_col, tbl_col_s  in  3  table column, plain and forced-shift.
- col_sel_n  in  COLS  VIA column drive, active low.
- row_sense_n  out  ROWS  row return, active low.
- busy  out  1  FSM not in IDLE, or queue not empty.
- overflow  out  1  sticky: event offered while full; cleared only by reset.

## Operation
- Queue: {code, press} FIFO. An event is written when key_valid && key_ready. If key_valid=1 while the queue is full, the event is dropped and overflow is set.
- Code record RAM: 128 entries of {held, row, col, row_s, col_s}. A record is written on a make and read on the matching break. Breaks never use the table, so a shift-state change between make and break cannot leave a key stuck.
- Position counters: one per matrix position, CNT_W bits. Increment saturates at all-ones; decrement stops at 0. A position is pressed when its counter ≠ 0. Two host keys mapped to the same position therefore release correctly.
- FSM states: IDLE, LOOK, SH_ON, WAIT_ON, KEY_ON, KEY_OFF, WAIT_OFF, SH_OFF.
  - IDLE: if the queue is non-empty, pop one event, drive tbl_code with its code and go to LOOK. Otherwise stay.
  - LOOK, make, record held=1: ignore (auto-repeat) and return to IDLE.
  - LOOK, make, tbl_row ≥ ROWS: store held=0 and return to IDLE.
  - LOOK, make, tbl_row_s < ROWS: store the record with held=1 and go to SH_ON.
  - LOOK, make, otherwise: store the record with held=1 and go to KEY_ON.
  - LOOK, break, record held=0: return to IDLE.
  - LOOK, break, record held=1: clear held and go to KEY_OFF.
  - SH_ON: increment (row_s, col_s), load the settle counter with SETTLE-1, go to WAIT_ON.
  - WAIT_ON: count down; at 0 go to KEY_ON.
  - KEY_ON: increment (row, col), go to IDLE.
  - KEY_OFF: decrement (row, col). If the stored row_s < ROWS, load SETTLE-1 and go to WAIT_OFF; otherwise go to IDLE.
  - WAIT_OFF: count down; at 0 go to SH_OFF.
  - SH_OFF: decrement (row_s, col_s), go to IDLE.
- all_up takes priority over everything. On the next edge: all counters and held bits clear, the FIFO empties, the FSM goes to IDLE, and overflow keeps its value. The held-bit clear may run as a 128-cycle background sweep. During the sweep key_ready=0 and busy=1.
- Row sense, registered: row_sense_n[r] = ~|(pressed[r][c] & ~col_sel_n[c]) over all c.

## Timing
- Reset values: key_ready=1, row_sense_n=all ones, tbl_code=0, busy=0, overflow=0. FIFO is empty, counters are 0, held bits are 0 (the sweep runs after reset release), FSM is in IDLE.
- Event-accept edge to FSM leaving IDLE: 1 cycle.
- tbl_* inputs must be valid one cycle after tbl_code changes; they are sampled in LOOK.
- Plain make: the counter increments 3 edges after accept (IDLE → LOOK → KEY_ON). Row sense reflects it 1 cycle later.
- Shifted make: shift counter at accept+3; key counter SETTLE+1 cycles after the shift counter.
- Break: mirror order; shift is released SETTLE+1 cycles after the key.
- col_sel_n to row_sense_n latency: exactly 1 cycle.
- Simultaneous FIFO write and pop on a full queue: the write is accepted.
- reset_n asserted mid-sequence: immediate return to reset values; no partial shift state survives.

## Test plan
- Plain make/break: make 0x04, col_sel_n=8'hFD → row_sense_n=8'hFB at accept+4. Break → 8'hFF.
- Shifted make, SETTLE=16: make 0x52 with tbl_row_s=3, col_s=1 → shift position (3,1) is set 17 cycles before key position (3,7). Break → (3,7) clears 17 cycles before (3,1).
- Shared position: make 0x2A, make 0x4C (both map to (0,7)), break 0x2A → (0,7) stays pressed; break 0x4C → released.
- Auto-repeat and stray break: three makes of 0x04 followed by one break → (2,1) released. A break of an unheld code changes no counter.
- Overflow: stall the FSM with SETTLE=1000 and push 9 events at FIFO_DEPTH=8 → key_ready=0 after the 8th and overflow=1. all_up → row_sense_n=all ones, busy falls after the sweep, overflow stays 1.
- Reset mid-WAIT_ON: assert reset_n low → all outputs return to reset values in the same cycle.
